// File: rtl/rv32_pkg.sv
// Shared RV32I constants for the instruction assembler/loader:
// base opcodes, the canonical NOP word and the loader FSM encoding.
package rv32_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // addi x0,x0,0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/instruc_encode.sv
// Combinational RV32I field packer: selects the instruction format from the
// opcode and flags any opcode outside the supported base set.
module instruc_encode
    import rv32_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        unsupported
);

    // Pack fields by format; unknown opcodes become a NOP and raise the flag
    always_comb begin
        word        = NOP_WORD;
        unsupported = 1'b0;
        case (opcode)
            OP_R:
                word = {funct7, rs2, rs1, funct3, rd, opcode};
            OP_IMM, OP_LOAD, OP_JALR:
                word = {imm[11:0], rs1, funct3, rd, opcode};
            OP_STORE:
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            OP_BRANCH:
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            OP_LUI, OP_AUIPC:
                word = {imm[31:12], rd, opcode};
            OP_JAL:
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: begin
                word        = NOP_WORD;
                unsupported = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instruc_assemble_loader.sv
// Instruction assembler/loader: accepts decoded RV32I field bundles, encodes
// them and writes one word every two cycles into instruction memory,
// starting at BASE_ADDR, until the last-marked word or DEPTH words.
module instruc_assemble_loader
    import rv32_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Wide enough to hold DEPTH-1 even for DEPTH=1
    localparam int CNT_W = $clog2(DEPTH + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [31:0]       enc_word;
    logic              enc_unsupported;

    instruc_encode u_encode (
        .opcode      (opcode),
        .rd          (rd),
        .funct3      (funct3),
        .rs1         (rs1),
        .rs2         (rs2),
        .funct7      (funct7),
        .imm         (imm),
        .word        (enc_word),
        .unsupported (enc_unsupported)
    );

    // Next-state, datapath and registered-output decode for the load session
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    addr_d  = BASE_ADDR;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (in_valid && in_ready_q) begin
                    wdata_d = enc_word;
                    last_d  = in_last;
                    if (enc_unsupported) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // The cap check uses the count of the word being written now
                if (last_q || (cnt_q == CNT_W'(DEPTH - 1))) begin
                    state_d = ST_DONE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(4);
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they register glitch-free
        in_ready_d = (state_d == ST_LOAD);
        mem_we_d   = (state_d == ST_WRITE);
        busy_d     = (state_d == ST_LOAD) || (state_d == ST_WRITE);
        done_d     = (state_d == ST_DONE);
    end

    // State, address/count and output registers; reset aborts any session
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= BASE_ADDR;
            cnt_q      <= '0;
            wdata_q    <= '0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            wdata_q    <= wdata_d;
            last_q     <= last_d;
            err_q      <= err_d;
            in_ready_q <= in_ready_d;
            mem_we_q   <= mem_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instruc_assemble_loader.sv
// Scoreboard bench for instruc_assemble_loader: stimulus pushes the expected
// memory writes, a negedge monitor pops and compares every mem_we pulse.
module tb_instruc_assemble_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_last = 1'b0;
    logic [6:0]  opcode = '0;
    logic [4:0]  rd = '0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] imm = '0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   wcyc[$];
    int   cycle = 0;
    int   errors = 0;
    int   checks = 0;

    instruc_assemble_loader #(
        .ADDR_W    (32),
        .BASE_ADDR (32'h0000_0000),
        .DEPTH     (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .opcode    (opcode),
        .rd        (rd),
        .funct3    (funct3),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct7    (funct7),
        .imm       (imm),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: every write strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (reset_n && mem_we) begin
            exp_t e;
            wcyc.push_back(cycle);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%h data=%h, required no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write: addr=%h data=%h, required addr=%h data=%h",
                             mem_addr, mem_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Present one bundle and wait for its handshake; in_valid is left high
    task automatic send(input logic [6:0] op, input logic [4:0] f_rd, input logic [2:0] f3,
                        input logic [4:0] f_rs1, input logic [4:0] f_rs2, input logic [6:0] f7,
                        input logic [31:0] f_imm, input logic last,
                        input logic [31:0] exp_addr, input logic [31:0] exp_data);
        bit ok;
        opcode = op; rd = f_rd; funct3 = f3; rs1 = f_rs1; rs2 = f_rs2;
        funct7 = f7; imm = f_imm; in_last = last; in_valid = 1'b1;
        exp_q.push_back('{addr: exp_addr, data: exp_data});
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: in_ready=0, required 1");
            void'(exp_q.pop_back());
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // 1: R-type single word
        pulse_start();
        check("t1_busy", {31'd0, busy}, 32'd1);
        send(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'h0, 1'b1, 32'h0, 32'h002081B3);
        idle();
        wait_done("t1_done");
        check("t1_err", {31'd0, err}, 32'd0);
        check("t1_busy_off", {31'd0, busy}, 32'd0);
        check("t1_sb_empty", exp_q.size(), 32'd0);

        // 2: I then S
        pulse_start();
        check("t2_done_drop", {31'd0, done}, 32'd0);
        send(7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'hFFF00293);
        send(7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8, 1'b1, 32'h4, 32'h0020A423);
        idle();
        wait_done("t2_done");
        check("t2_sb_empty", exp_q.size(), 32'd0);

        // 3: B/J/U back to back, in_valid held high
        pulse_start();
        wcyc.delete();
        send(7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'hFE208EE3);
        send(7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd8, 1'b0, 32'h4, 32'h008000EF);
        send(7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5000, 1'b1, 32'h8, 32'h123452B7);
        idle();
        wait_done("t3_done");
        check("t3_sb_empty", exp_q.size(), 32'd0);
        check("t3_nwrites", wcyc.size(), 32'd3);
        if (wcyc.size() == 3) begin
            check("t3_gap01", wcyc[1] - wcyc[0], 32'd2);
            check("t3_gap12", wcyc[2] - wcyc[1], 32'd2);
        end

        // 4: unsupported opcode -> NOP and sticky err
        pulse_start();
        send(7'h7F, 5'd3, 3'd1, 5'd4, 5'd5, 7'd1, 32'h1234, 1'b1, 32'h0, 32'h0000_0013);
        idle();
        wait_done("t4_done");
        check("t4_err", {31'd0, err}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("t4_err_sticky", {31'd0, err}, 32'd1);
        pulse_start();
        check("t4_err_clear", {31'd0, err}, 32'd0);
        check("t4_done_clear", {31'd0, done}, 32'd0);
        send(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'h0, 1'b1, 32'h0, 32'h002081B3);
        idle();
        wait_done("t4b_done");
        check("t4b_err", {31'd0, err}, 32'd0);

        // 5: DEPTH=4 cap without in_last
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            send(7'h13, 5'(k + 1), 3'd0, 5'd0, 5'd0, 7'd0, 32'(k),
                 1'b0, 32'(4 * k), {12'(k), 5'd0, 3'd0, 5'(k + 1), 7'h13});
        end
        // Keep offering words; none may be accepted
        in_valid = 1'b1;
        wait_done("t5_done");
        repeat (6) begin
            @(negedge clk);
            check("t5_in_ready", {31'd0, in_ready}, 32'd0);
        end
        idle();
        check("t5_sb_empty", exp_q.size(), 32'd0);
        check("t5_last_addr", mem_addr, 32'hC);

        // 6: reset during WRITE
        pulse_start();
        send(7'h13, 5'd7, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1, 1'b0, 32'h0, 32'h00100393);
        idle();
        check("t6_we_before", {31'd0, mem_we}, 32'd1);
        @(negedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("t6_we_async", {31'd0, mem_we}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_done", {31'd0, done}, 32'd0);
        check("t6_addr", mem_addr, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        pulse_start();
        send(7'h17, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'hABCD_E000, 1'b1, 32'h0, 32'hABCDE117);
        idle();
        wait_done("t6_done_after");
        check("t6_sb_empty", exp_q.size(), 32'd0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

endmodule
